// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between requester A (CPU MEM
// stage) and requester B (DMA/debug). Each access takes IDLE -> ACCESS -> DONE.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin arbitration); when it is
// undefined, A has fixed priority over B.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                win_b_q, win_b_d;
  logic                grant_b;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                misaligned;
  logic                mem_ce_d, mem_we_d, busy_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                a_ack_d, a_err_d, b_ack_d, b_err_d;
  logic [DATA_W-1:0]   a_rdata_d, b_rdata_d;
`ifdef DMEM_ARB_RR_EN
  logic                last_grant_b_q, last_grant_b_d;
`endif

  // Arbitration: pick the port to serve if a grant happens this cycle
`ifdef DMEM_ARB_RR_EN
  assign grant_b = b_req & (~a_req | ~last_grant_b_q);
`else
  assign grant_b = b_req & ~a_req;
`endif
  assign sel_we     = grant_b ? b_we    : a_we;
  assign sel_addr   = grant_b ? b_addr  : a_addr;
  assign sel_wdata  = grant_b ? b_wdata : a_wdata;
  assign misaligned = (sel_addr[1:0] != 2'b00);

  // Next state and next values of all registered outputs
  always_comb begin
    state_d     = state_q;
    win_b_d     = win_b_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    busy_d      = 1'b0;
    a_ack_d     = 1'b0;
    a_err_d     = 1'b0;
    b_ack_d     = 1'b0;
    b_err_d     = 1'b0;
    a_rdata_d   = a_rdata;
    b_rdata_d   = b_rdata;
`ifdef DMEM_ARB_RR_EN
    last_grant_b_d = last_grant_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          win_b_d = grant_b;
          busy_d  = 1'b1;
          if (misaligned) begin
            // No RAM cycle: report the error straight away
            state_d = DONE;
            a_ack_d = ~grant_b;
            a_err_d = ~grant_b;
            b_ack_d = grant_b;
            b_err_d = grant_b;
          end else begin
            state_d     = ACCESS;
            mem_ce_d    = 1'b1;
            mem_we_d    = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
          end
        end
      end
      ACCESS: begin
        state_d = DONE;
        busy_d  = 1'b1;
        a_ack_d = ~win_b_q;
        b_ack_d = win_b_q;
        if (!mem_we) begin
          if (win_b_q) b_rdata_d = mem_rdata;
          else         a_rdata_d = mem_rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef DMEM_ARB_RR_EN
        last_grant_b_d = win_b_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      win_b_q   <= 1'b0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      a_ack     <= 1'b0;
      a_err     <= 1'b0;
      b_ack     <= 1'b0;
      b_err     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant_b_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      win_b_q   <= win_b_d;
      mem_ce    <= mem_ce_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
      a_ack     <= a_ack_d;
      a_err     <= a_err_d;
      b_ack     <= b_ack_d;
      b_err     <= b_err_d;
      a_rdata   <= a_rdata_d;
      b_rdata   <= b_rdata_d;
`ifdef DMEM_ARB_RR_EN
      last_grant_b_q <= last_grant_b_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level model with a shadow memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [10:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_ce, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  wire  [31:0] mem_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // Bench RAM (512 words) and the model's view of what it should hold
  logic [31:0] ram    [512];
  logic [31:0] shadow [512];
  logic        ram_init = 1'b1;
  bit          lg_b;          // model: last served port was B
  logic [31:0] exp_ar, exp_br;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_ce ? ram[mem_addr[10:2]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'(i) * 32'h9E37_79B1;
    end else if (mem_ce && mem_we) begin
      ram[mem_addr[10:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit rq, input bit we, input logic [10:0] ad, input logic [31:0] wd);
    a_req = rq; a_we = we; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input bit rq, input bit we, input logic [10:0] ad, input logic [31:0] wd);
    b_req = rq; b_we = we; b_addr = ad; b_wdata = wd;
  endtask

  // One arbitration slot starting in IDLE; returns in the following IDLE cycle
  task automatic do_slot(input bit scramble, output bit sa, output bit sb);
    bit          gb, we, err;
    logic [10:0] ad;
    logic [31:0] wd;
    int          idx;
    sa = 0; sb = 0;
    if (!a_req && !b_req) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_ce", mem_ce, 0);
      chk("idle_acks", {a_ack, b_ack}, 0);
      return;
    end
    if (a_req && b_req) gb = RR ? !lg_b : 1'b0;
    else                gb = b_req;
    we  = gb ? b_we    : a_we;
    ad  = gb ? b_addr  : a_addr;
    wd  = gb ? b_wdata : a_wdata;
    err = (ad % 4) != 0;
    idx = int'(ad) / 4;
    sa = !gb; sb = gb;
    tick();
    chk("busy1", busy, 1);
    if (err) begin
      chk("err_ce", mem_ce, 0);
      chk("err_we", mem_we, 0);
      chk("err_acks", {a_ack, b_ack}, {30'd0, sa, sb});
      chk("err_flags", {a_err, b_err}, {30'd0, sa, sb});
    end else begin
      chk("acc_ce", mem_ce, 1);
      chk("acc_we", mem_we, we);
      chk("acc_addr", mem_addr, ad);
      if (we) chk("acc_wdata", mem_wdata, wd);
      chk("acc_acks", {a_ack, b_ack}, 0);
      if (scramble) begin
        if (gb) set_b($urandom_range(0, 1), $urandom_range(0, 1), 11'($urandom), $urandom);
        else    set_a($urandom_range(0, 1), $urandom_range(0, 1), 11'($urandom), $urandom);
      end
      tick();
      if (we) shadow[idx] = wd;
      else if (gb) exp_br = shadow[idx];
      else exp_ar = shadow[idx];
      chk("done_busy", busy, 1);
      chk("done_ce", mem_ce, 0);
      chk("done_we", mem_we, 0);
      chk("done_addr_hold", mem_addr, ad);
      chk("done_acks", {a_ack, b_ack}, {30'd0, sa, sb});
      chk("done_errs", {a_err, b_err}, 0);
    end
    chk("a_rdata", a_rdata, exp_ar);
    chk("b_rdata", b_rdata, exp_br);
    chk("ram_word", ram[idx], shadow[idx]);
    lg_b = gb;
    tick();
    chk("back_idle_busy", busy, 0);
    chk("back_idle_acks", {a_ack, b_ack}, 0);
  endtask

  task automatic new_op(output bit rq, output bit we, output logic [10:0] ad, output logic [31:0] wd);
    rq = $urandom_range(0, 3) != 0;
    we = $urandom_range(0, 1) != 0;
    ad = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 63));
    if ($urandom_range(0, 7) != 0) ad[1:0] = 2'b00;
    wd = $urandom;
  endtask

  initial begin
    bit          sa, sb, rq, we;
    logic [10:0] ad;
    logic [31:0] wd;
    for (int i = 0; i < 512; i++) shadow[i] = 32'(i) * 32'h9E37_79B1;
    lg_b = 1; exp_ar = 0; exp_br = 0;
    rst = 1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick(); tick();
    ram_init = 1'b0;
    tick();
    chk("rst_outs", {a_ack, a_err, b_ack, b_err, mem_ce, mem_we, busy}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", a_rdata | b_rdata, 0);

    // Both requesters at reset exit: A write 0x010, B write to IO 0x404
    set_a(1, 1, 11'h010, 32'hDEAD_BEEF);
    set_b(1, 1, 11'h404, 32'h55AA_55AA);
    rst = 0;
    do_slot(0, sa, sb);
    set_a(1, 0, 11'h010, 32'h0);
    do_slot(0, sa, sb);
    if (sb) set_b(0, 0, 0, 0);
    do_slot(0, sa, sb);
    if (sb) set_b(0, 0, 0, 0);
    set_a(0, 0, 0, 0);
    do_slot(0, sa, sb);
    if (sb) set_b(0, 0, 0, 0);
    do_slot(0, sa, sb);
    chk("readback_deadbeef", a_rdata, 32'hDEAD_BEEF);

    // Misaligned read then misaligned write
    set_a(1, 0, 11'h013, 32'h0);
    do_slot(0, sa, sb);
    set_a(1, 1, 11'h012, 32'h1234_5678);
    do_slot(0, sa, sb);

    // Back-to-back aligned reads
    set_a(1, 0, 11'h000, 32'h0);
    do_slot(0, sa, sb);
    set_a(1, 0, 11'h004, 32'h0);
    do_slot(1, sa, sb);
    set_a(0, 0, 0, 0);
    do_slot(0, sa, sb);

    // Reset pulsed during the ACCESS cycle of a write
    set_a(1, 1, 11'h020, 32'hCAFE_F00D);
    tick();
    chk("pre_rst_ce", mem_ce, 1);
    #2 rst = 1;
    #1;
    chk("midrst_outs", {a_ack, b_ack, mem_ce, mem_we, busy}, 0);
    chk("midrst_addr", mem_addr, 0);
    set_a(0, 0, 0, 0);
    tick(); tick();
    rst = 0;
    lg_b = 1; exp_ar = 0; exp_br = 0;
    chk("rst_no_commit", ram[8], shadow[8]);
    chk("rst_rdata_clr", a_rdata, 0);
    set_a(1, 1, 11'h020, 32'hCAFE_F00D);
    do_slot(0, sa, sb);
    set_a(0, 0, 0, 0);

    // Random traffic; a loser keeps its request unchanged
    for (int s = 0; s < 300; s++) begin
      do_slot($urandom_range(0, 3) == 0, sa, sb);
      if (sa || !a_req) begin new_op(rq, we, ad, wd); set_a(rq, we, ad, wd); end
      if (sb || !b_req) begin new_op(rq, we, ad, wd); set_b(rq, we, ad, wd); end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
